// File: rtl/uart_dump_scheduler.sv
// Streams a block of 16-bit sample words from the sample RAM to a UART byte transmitter, low byte first.
// Optional feature macro UART_DUMP_CHECKSUM_EN appends one XOR checksum byte after the block.
module uart_dump_scheduler #(
    parameter int ADDR_W      = 14,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic [ADDR_W-1:0] rd_address,
    input  logic [15:0]       rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_en,
    input  logic              tx_rdy,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] word_count
);

    localparam int                TMO_W     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0]  TMO_ZERO  = {TMO_W{1'b0}};
    localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_READ     = 4'd1,
        S_LOAD     = 4'd2,
        S_SEND_LO  = 4'd3,
        S_ACK_LO   = 4'd4,
        S_DRAIN_LO = 4'd5,
        S_SEND_HI  = 4'd6,
        S_ACK_HI   = 4'd7,
        S_DRAIN_HI = 4'd8,
        S_NEXT     = 4'd9,
        S_DONE     = 4'd10,
        S_SEND_CS  = 4'd11,
        S_ACK_CS   = 4'd12,
        S_DRAIN_CS = 4'd13
    } state_t;

`ifdef UART_DUMP_CHECKSUM_EN
    localparam state_t S_AFTER_LAST = S_SEND_CS;

    function automatic logic [7:0] cs_next(input logic [7:0] cs, input logic [7:0] b);
        return cs ^ b;
    endfunction

    logic [7:0] cs_q, cs_d;
`else
    localparam state_t S_AFTER_LAST = S_DONE;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [15:0]       word_q, word_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [ADDR_W-1:0] rd_address_q, rd_address_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_en_q, tx_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] word_count_q, word_count_d;
    logic [ADDR_W-1:0] idx_inc_s;

    assign idx_inc_s = idx_q + ADDR_ONE;

    // Next-state and registered-output computation for the dump sequencer.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        len_d        = len_q;
        idx_d        = idx_q;
        word_d       = word_q;
        tmo_d        = tmo_q;
        rd_address_d = rd_address_q;
        tx_data_d    = tx_data_q;
        tx_en_d      = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = error_q;
        word_count_d = word_count_q;
`ifdef UART_DUMP_CHECKSUM_EN
        cs_d         = cs_q;
`endif
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        base_d       = base_addr;
                        len_d        = length;
                        idx_d        = ADDR_ZERO;
                        word_count_d = ADDR_ZERO;
                        error_d      = 1'b0;
                        busy_d       = 1'b1;
`ifdef UART_DUMP_CHECKSUM_EN
                        cs_d         = 8'h00;
`endif
                        if (length == ADDR_ZERO) begin
                            state_d = S_AFTER_LAST;
                        end else begin
                            // Address is registered here so it is stable for the whole READ cycle.
                            rd_address_d = base_addr;
                            state_d      = S_READ;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_READ: state_d = S_LOAD;
                S_LOAD: begin
                    word_d  = rd_data;
                    state_d = S_SEND_LO;
                end
                S_SEND_LO: begin
                    if (tx_rdy) begin
                        tx_data_d = word_q[7:0];
                        tx_en_d   = 1'b1;
                        tmo_d     = TMO_ZERO;
`ifdef UART_DUMP_CHECKSUM_EN
                        cs_d      = cs_next(cs_q, word_q[7:0]);
`endif
                        state_d   = S_ACK_LO;
                    end else begin
                        state_d = S_SEND_LO;
                    end
                end
                S_ACK_LO: begin
                    if (!tx_rdy) begin
                        state_d = S_DRAIN_LO;
                    end else if (tmo_q == TMO_LAST) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        tmo_d = tmo_q + TMO_ONE;
                    end
                end
                S_DRAIN_LO: state_d = tx_rdy ? S_SEND_HI : S_DRAIN_LO;
                S_SEND_HI: begin
                    if (tx_rdy) begin
                        tx_data_d = word_q[15:8];
                        tx_en_d   = 1'b1;
                        tmo_d     = TMO_ZERO;
`ifdef UART_DUMP_CHECKSUM_EN
                        cs_d      = cs_next(cs_q, word_q[15:8]);
`endif
                        state_d   = S_ACK_HI;
                    end else begin
                        state_d = S_SEND_HI;
                    end
                end
                S_ACK_HI: begin
                    if (!tx_rdy) begin
                        state_d = S_DRAIN_HI;
                    end else if (tmo_q == TMO_LAST) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        tmo_d = tmo_q + TMO_ONE;
                    end
                end
                S_DRAIN_HI: state_d = tx_rdy ? S_NEXT : S_DRAIN_HI;
                S_NEXT: begin
                    word_count_d = word_count_q + ADDR_ONE;
                    idx_d        = idx_inc_s;
                    if (idx_inc_s == len_q) begin
                        state_d = S_AFTER_LAST;
                    end else begin
                        rd_address_d = base_q + idx_inc_s;
                        state_d      = S_READ;
                    end
                end
                S_DONE: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
`ifdef UART_DUMP_CHECKSUM_EN
                S_SEND_CS: begin
                    if (tx_rdy) begin
                        tx_data_d = cs_q;
                        tx_en_d   = 1'b1;
                        tmo_d     = TMO_ZERO;
                        state_d   = S_ACK_CS;
                    end else begin
                        state_d = S_SEND_CS;
                    end
                end
                S_ACK_CS: begin
                    if (!tx_rdy) begin
                        state_d = S_DRAIN_CS;
                    end else if (tmo_q == TMO_LAST) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        tmo_d = tmo_q + TMO_ONE;
                    end
                end
                S_DRAIN_CS: state_d = tx_rdy ? S_DONE : S_DRAIN_CS;
`endif
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset clears everything asynchronously, including tx_en.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            base_q       <= {ADDR_W{1'b0}};
            len_q        <= {ADDR_W{1'b0}};
            idx_q        <= {ADDR_W{1'b0}};
            word_q       <= 16'h0000;
            tmo_q        <= {TMO_W{1'b0}};
            rd_address_q <= {ADDR_W{1'b0}};
            tx_data_q    <= 8'h00;
            tx_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            word_count_q <= {ADDR_W{1'b0}};
`ifdef UART_DUMP_CHECKSUM_EN
            cs_q         <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            tmo_q        <= tmo_d;
            rd_address_q <= rd_address_d;
            tx_data_q    <= tx_data_d;
            tx_en_q      <= tx_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            word_count_q <= word_count_d;
`ifdef UART_DUMP_CHECKSUM_EN
            cs_q         <= cs_d;
`endif
        end
    end

    assign rd_address = rd_address_q;
    assign tx_data    = tx_data_q;
    assign tx_en      = tx_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_uart_dump_scheduler.sv
// Directed testbench for uart_dump_scheduler: RAM and transmitter models, byte scoreboard, timing checks.
module tb_uart_dump_scheduler;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] length;
    logic [AW-1:0] rd_address;
    logic [15:0]   rd_data;
    logic [7:0]    tx_data;
    logic          tx_en;
    logic          tx_rdy;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] word_count;

    int checks = 0;
    int errors = 0;
    int tx_seen = 0;
    int done_seen = 0;
    logic prev_en = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] tb_cs;
    logic [15:0] mem [0:(1<<AW)-1];
    bit no_ack = 1'b0;
    int tx_phase;

    uart_dump_scheduler #(.ADDR_W(AW), .ACK_TIMEOUT(8)) dut (
        .CLOCK_50  (clk),
        .RESET     (rst),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .length    (length),
        .rd_address(rd_address),
        .rd_data   (rd_data),
        .tx_data   (tx_data),
        .tx_en     (tx_en),
        .tx_rdy    (tx_rdy),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Synchronous sample RAM: data valid the cycle after the address.
    always @(posedge clk) rd_data <= mem[rd_address];

    // Transmitter: registers transmit_en, drops ready 2 cycles after tx_en, busy for 3 cycles.
    always @(posedge clk) begin
        if (rst) begin
            tx_rdy   <= 1'b1;
            tx_phase <= 0;
        end else if (tx_phase == 0) begin
            if (tx_en && !no_ack) tx_phase <= 1;
        end else if (tx_phase == 4) begin
            tx_rdy   <= 1'b1;
            tx_phase <= 0;
        end else begin
            if (tx_phase == 1) tx_rdy <= 1'b0;
            tx_phase <= tx_phase + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Byte monitor: every tx_en pops and compares one expected byte.
    always @(negedge clk) begin
        if (!rst && tx_en) begin
            tx_seen++;
            check("tx_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            check("tx_en_gap", 32'(prev_en), 32'd0);
        end
        prev_en = tx_en;
        if (done) done_seen++;
    end

    task automatic push_byte(input logic [7:0] b);
        exp_q.push_back(b);
        tb_cs = tb_cs ^ b;
    endtask

    task automatic push_word(input logic [15:0] w);
        push_byte(w[7:0]);
        push_byte(w[15:8]);
    endtask

    task automatic push_cs();
        exp_q.push_back(tb_cs);
    endtask

    task automatic start_dump(input logic [AW-1:0] b, input logic [AW-1:0] n, input logic ab);
        @(posedge clk); #1;
        base_addr = b; length = n; start = 1'b1; abort = ab;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_tx(input int target, input int budget);
        int cyc = 0;
        while (tx_seen < target && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("tx_wait", 32'(tx_seen >= target), 32'd1);
    endtask

    task automatic wait_done(input int budget, output int cyc);
        int d0 = done_seen;
        cyc = 0;
        while (done_seen == d0 && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("done_wait", 32'(done_seen != d0), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int d0;
        int t0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; length = '0;
        tb_cs = 8'h00;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0000;
        mem[14'h0010] = 16'hBEEF;
        mem[14'h0011] = 16'h1234;
        mem[14'h3FFF] = 16'hA55A;
        mem[14'h0000] = 16'h0FF0;
        mem[14'h0020] = 16'h00C3;
        for (int i = 0; i < 5; i++) mem[14'h0040 + i] = 16'h1100 + 16'(i * 16'h0111);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_rd_address", 32'(rd_address), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);

        // Basic dump with first-byte latency.
        tb_cs = 8'h00;
        push_byte(8'hEF); push_byte(8'hBE); push_byte(8'h34); push_byte(8'h12);
`ifdef UART_DUMP_CHECKSUM_EN
        push_cs();
`endif
        d0 = done_seen;
        start_dump(14'h0010, 14'd2, 1'b0);
        check("basic_busy", 32'(busy), 32'd1);
        repeat (2) @(posedge clk);
        #1 check("first_tx_early", 32'(tx_en), 32'd0);
        @(posedge clk);
        #1 check("first_tx_latency", 32'(tx_en), 32'd1);
        check("first_tx_data", 32'(tx_data), 32'hEF);
        wait_done(400, cyc);
        check("basic_word_count", 32'(word_count), 32'd2);
        check("basic_error", 32'(error), 32'd0);
        check("basic_busy_end", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1 check("basic_done_once", 32'(done_seen - d0), 32'd1);
        check("basic_queue_empty", 32'(exp_q.size()), 32'd0);

        // Address wrap from the top of RAM to 0.
        tb_cs = 8'h00;
        push_word(16'hA55A); push_word(16'h0FF0);
`ifdef UART_DUMP_CHECKSUM_EN
        push_cs();
`endif
        start_dump(14'h3FFF, 14'd2, 1'b0);
        wait_done(400, cyc);
        check("wrap_word_count", 32'(word_count), 32'd2);
        check("wrap_last_addr", 32'(rd_address), 32'd0);
        check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

        // Ack timeout: transmitter never drops ready.
        no_ack = 1'b1;
        tb_cs = 8'h00;
        push_byte(8'hC3);
        t0 = tx_seen;
        start_dump(14'h0020, 14'd1, 1'b0);
        wait_tx(t0 + 1, 20);
        wait_done(30, cyc);
        check("timeout_done_latency", 32'(cyc), 32'd9);
        check("timeout_error", 32'(error), 32'd1);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_word_count", 32'(word_count), 32'd0);
        no_ack = 1'b0;
        repeat (2) @(posedge clk);

        // Abort during DRAIN_HI of word 3 of 5.
        tb_cs = 8'h00;
        for (int i = 0; i < 3; i++) push_word(16'h1100 + 16'(i * 16'h0111));
        t0 = tx_seen;
        d0 = done_seen;
        start_dump(14'h0040, 14'd5, 1'b0);
        check("start_clears_error", 32'(error), 32'd0);
        wait_tx(t0 + 6, 300);
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_word_count", 32'(word_count), 32'd2);
        repeat (20) @(posedge clk);
        #1 check("abort_no_done", 32'(done_seen), 32'(d0));
        check("abort_no_more_tx", 32'(tx_seen), 32'(t0 + 6));
        check("abort_queue_empty", 32'(exp_q.size()), 32'd0);

        // Clean restart after abort.
        tb_cs = 8'h00;
        push_word(16'hBEEF); push_word(16'h1234);
`ifdef UART_DUMP_CHECKSUM_EN
        push_cs();
`endif
        start_dump(14'h0010, 14'd2, 1'b0);
        check("restart_clears_wc", 32'(word_count), 32'd0);
        wait_done(400, cyc);
        check("restart_word_count", 32'(word_count), 32'd2);
        check("restart_error", 32'(error), 32'd0);

        // Zero-length dump.
        tb_cs = 8'h00;
        t0 = tx_seen;
`ifdef UART_DUMP_CHECKSUM_EN
        push_cs();
        start_dump(14'h0005, 14'd0, 1'b0);
        wait_done(100, cyc);
        check("len0_cs_sent", 32'(tx_seen), 32'(t0 + 1));
`else
        start_dump(14'h0005, 14'd0, 1'b0);
        check("len0_done_early", 32'(done), 32'd0);
        check("len0_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1 check("len0_done_latency", 32'(done), 32'd1);
        check("len0_busy_end", 32'(busy), 32'd0);
        @(posedge clk);
        #1 check("len0_done_pulse", 32'(done), 32'd0);
        check("len0_no_tx", 32'(tx_seen), 32'(t0));
`endif
        check("len0_word_count", 32'(word_count), 32'd0);

        // Simultaneous start and abort in IDLE.
        d0 = done_seen;
        t0 = tx_seen;
        start_dump(14'h0010, 14'd2, 1'b1);
        check("start_abort_busy", 32'(busy), 32'd0);
        repeat (5) @(posedge clk);
        #1 check("start_abort_idle", 32'(busy), 32'd0);
        check("start_abort_no_done", 32'(done_seen), 32'(d0));
        check("start_abort_no_tx", 32'(tx_seen), 32'(t0));

        // Reset asserted while the first byte's tx_en pulse is high.
        start_dump(14'h0010, 14'd2, 1'b0);
        repeat (3) @(posedge clk);
        #1 check("pre_reset_tx_en", 32'(tx_en), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_tx_en", 32'(tx_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rd_address", 32'(rd_address), 32'd0);
        check("mid_rst_tx_data", 32'(tx_data), 32'd0);
        check("mid_rst_word_count", 32'(word_count), 32'd0);
        check("mid_rst_error", 32'(error), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("post_rst_busy", 32'(busy), 32'd0);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
